fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the load-use hazard unit and consumes that unit's PCWrite/IF_ID_Write stall outputs. It owns the PC, issues requests to a variable-latency instruction memory and handles branch/jump redirects. It delivers {instr, pc_plus4, valid} to ID and flushes on redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    localparam word_t NOP_INSTR_DEF = 32'h0000_0000;
    localparam word_t RESET_PC_DEF  = 32'h0000_0000;

    function automatic word_t pc_inc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; resets to a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    input  logic  load,
    input  word_t instr_in,
    input  word_t pc_plus4_in,
    output word_t instr,
    output word_t pc_plus4,
    output logic  valid
);

    word_t instr_q, instr_d;
    word_t pc_plus4_q, pc_plus4_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a variable-latency imem, feeds IF/ID.
// A response that cannot be accepted parks in hold_buf; redirects during a miss wait for ready.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEF,
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] pc_out
);

    word_t        pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic         redir_pending_q, redir_pending_d;
    word_t        redir_pc_q, redir_pc_d;
    word_t        hold_buf_q, hold_buf_d;

    logic  accept, redirect;
    word_t target, pc_plus4;
    logic  ifid_load, ifid_flush;
    word_t ld_instr;

    assign accept   = pc_write & if_id_write;
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_inc(pc_q);

    always_comb begin
        pc_d            = pc_q;
        state_d         = state_q;
        redir_pending_d = redir_pending_q;
        redir_pc_d      = redir_pc_q;
        hold_buf_d      = hold_buf_q;
        ifid_load       = 1'b0;
        ifid_flush      = 1'b0;
        ld_instr        = (state_q == ST_HOLD) ? hold_buf_q : imem_rdata;

        case (state_q)
            ST_REQ: begin
                if (imem_ready) begin
                    if (redirect || redir_pending_q) begin
                        // Stale response for the pre-redirect address is dropped.
                        pc_d            = redirect ? target : redir_pc_q;
                        redir_pending_d = 1'b0;
                        ifid_flush      = if_id_write;
                    end else if (accept) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect) begin
                    redir_pc_d      = target;
                    redir_pending_d = 1'b1;
                end else begin
                    ifid_flush = if_id_write;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_REQ;
                end else if (accept) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect) begin
            ifid_flush = 1'b1;
            ifid_load  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            state_q         <= ST_REQ;
            redir_pending_q <= 1'b0;
            redir_pc_q      <= RESET_PC;
            hold_buf_q      <= NOP_INSTR;
        end else begin
            pc_q            <= pc_d;
            state_q         <= state_d;
            redir_pending_q <= redir_pending_d;
            redir_pc_q      <= redir_pc_d;
            hold_buf_q      <= hold_buf_d;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .flush       (ifid_flush),
        .load        (ifid_load),
        .instr_in    (ld_instr),
        .pc_plus4_in (pc_plus4),
        .instr       (if_id_instr),
        .pc_plus4    (if_id_pc_plus4),
        .valid       (if_id_valid)
    );

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;

endmodule
